// File: rtl/fetch_sequencer.sv
// Instruction-fetch stage: owns the PC, slices opcode/lastBit for the decoder, applies branches, detects halt.
// Optional `define FETCH_INSTR_COUNT_EN adds a saturating 32-bit instr_count output.
module fetch_sequencer #(
  parameter int INSTR_W    = 9,
  parameter int PC_W       = 10,
  parameter int START_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] instr_data,
  output logic [PC_W-1:0]    instr_addr,
  output logic [2:0]         opcode,
  output logic               lastBit,
  output logic               instr_valid,
  output logic               prep_mode,
  output logic               done,
  output logic               pc_wrap
`ifdef FETCH_INSTR_COUNT_EN
  ,
  output logic [31:0]        instr_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [2:0] OP_PREP   = 3'b000;
  localparam logic [2:0] OP_HALT   = 3'b111;
  localparam logic [2:0] OP_BUBBLE = 3'b110;

  state_t          state;
  state_t          nextState;
  logic [PC_W-1:0] pc;
  logic            prepMode;
  logic            pcWrap;
  logic [2:0]      rawOp;
  logic            haltNow;
  logic            loadStart;
  logic [PC_W:0]   pcInc;

  assign rawOp     = instr_data[INSTR_W-1 -: 3];
  assign haltNow   = (state == RUN) && !prepMode && (rawOp == OP_HALT);
  assign loadStart = start && (state != RUN);
  assign pcInc     = {1'b0, pc} + (PC_W+1)'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = RUN;
      RUN:     if (haltNow) nextState = HALT;
      HALT:    if (start) nextState = RUN;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    instr_valid = (state == RUN);
    done        = (state == HALT);
    opcode      = OP_BUBBLE;
    lastBit     = 1'b0;
    if (state == RUN) begin
      opcode  = rawOp;
      lastBit = instr_data[0];
    end
  end

  // The halting instruction freezes the PC on its own address; a taken branch cannot override it.
  // Prep mode survives PSFT/110/111 so a 111 inside prep mode is a no-op rather than a halt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= START_PC;
      prepMode <= 1'b0;
      pcWrap   <= 1'b0;
    end else if (loadStart) begin
      pc       <= START_PC;
      prepMode <= 1'b0;
      pcWrap   <= 1'b0;
    end else if (state == RUN) begin
      if (!haltNow) begin
        if (branch_taken) begin
          pc <= branch_target;
        end else begin
          pc <= pcInc[PC_W-1:0];
          if (pcInc[PC_W]) pcWrap <= 1'b1;
        end
      end
      if (!prepMode) prepMode <= (rawOp == OP_PREP);
      else           prepMode <= (rawOp >= 3'b101);
    end
  end

  assign instr_addr = pc;
  assign prep_mode  = prepMode;
  assign pc_wrap    = pcWrap;

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] countReg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   countReg <= '0;
    else if (loadStart)                          countReg <= '0;
    else if (state == RUN && countReg != '1)     countReg <= countReg + 32'd1;
  end

  assign instr_count = countReg;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a 10-bit-PC instance plus a 4-bit-PC instance for wrap behaviour.
// Also checks instr_count when FETCH_INSTR_COUNT_EN is defined.
module tb_fetch_sequencer;

  typedef struct packed {
    logic [9:0] addr;
    logic [2:0] op;
    logic       valid;
    logic       last;
    logic       prep;
    logic       dn;
    logic       wrap;
  } obs_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic       branchTaken;
  logic [9:0] branchTarget;
  logic [8:0] instrData;
  logic [9:0] instrAddr;
  logic [2:0] opcode;
  logic       lastBit;
  logic       instrValid;
  logic       prepMode;
  logic       done;
  logic       pcWrap;

  logic       start4;
  logic       branchTaken4;
  logic [3:0] branchTarget4;
  logic [8:0] instrData4;
  logic [3:0] instrAddr4;
  logic [2:0] opcode4;
  logic       lastBit4;
  logic       instrValid4;
  logic       prepMode4;
  logic       done4;
  logic       pcWrap4;

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] instrCount;
  logic [31:0] instrCount4;
`endif

  logic [8:0] rom  [1024];
  logic [8:0] rom4 [16];

  obs_t sbq[$];
  int   checks = 0;
  int   passed = 0;

  assign instrData  = rom[instrAddr];
  assign instrData4 = rom4[instrAddr4];

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .instr_data    (instrData),
    .instr_addr    (instrAddr),
    .opcode        (opcode),
    .lastBit       (lastBit),
    .instr_valid   (instrValid),
    .prep_mode     (prepMode),
    .done          (done),
    .pc_wrap       (pcWrap)
`ifdef FETCH_INSTR_COUNT_EN
    ,
    .instr_count   (instrCount)
`endif
  );

  fetch_sequencer #(.INSTR_W(9), .PC_W(4), .START_ADDR(0)) dut4 (
    .clk           (clk),
    .reset         (reset),
    .start         (start4),
    .branch_taken  (branchTaken4),
    .branch_target (branchTarget4),
    .instr_data    (instrData4),
    .instr_addr    (instrAddr4),
    .opcode        (opcode4),
    .lastBit       (lastBit4),
    .instr_valid   (instrValid4),
    .prep_mode     (prepMode4),
    .done          (done4),
    .pc_wrap       (pcWrap4)
`ifdef FETCH_INSTR_COUNT_EN
    ,
    .instr_count   (instrCount4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mainObs();
    return {instrAddr, opcode, instrValid, lastBit, prepMode, done, pcWrap};
  endfunction

  function automatic obs_t wrapObs();
    return {6'd0, instrAddr4, opcode4, instrValid4, lastBit4, prepMode4, done4, pcWrap4};
  endfunction

  function automatic void pushExp(input logic [9:0] a, input logic [2:0] op, input logic v,
                                  input logic lb, input logic pm, input logic dn, input logic wr);
    sbq.push_back({a, op, v, lb, pm, dn, wr});
  endfunction

  task automatic fillInc();
    for (int i = 0; i < 1024; i++) rom[i] = 9'h040 | 9'(i & 1);
    for (int i = 0; i < 16; i++) rom4[i] = 9'h040 | 9'(i & 1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    branchTaken = 1'b0;
    branchTarget = '0;
    start4 = 1'b0;
    branchTaken4 = 1'b0;
    branchTarget4 = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e;
    obs_t o;
    doReset();
    fillInc();
    pushExp(10'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    e = sbq.pop_front(); o = mainObs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_idle got=%h exp=%h", o, e); else passed++;
    branchTaken = 1'b1;
    branchTarget = 10'h055;
    pushExp(10'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    e = sbq.pop_front(); o = mainObs(); checks++;
    if (o !== e) $display("[TB] FAIL idle_branch got=%h exp=%h", o, e); else passed++;
    branchTaken = 1'b0;
    start = 1'b1;
    pushExp(10'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(10'd1, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      e = sbq.pop_front(); o = mainObs(); checks++;
      if (o !== e) $display("[TB] FAIL reset_prerun got=%h exp=%h", o, e); else passed++;
    end
    @(posedge clk);
    #2 reset = 1'b1;
    pushExp(10'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    e = sbq.pop_front(); o = mainObs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_async got=%h exp=%h", o, e); else passed++;
    @(negedge clk);
    reset = 1'b0;
    pushExp(10'd0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    e = sbq.pop_front(); o = mainObs(); checks++;
    if (o !== e) $display("[TB] FAIL reset_release got=%h exp=%h", o, e); else passed++;
  endtask

  // A start pulse while running (sampled at addr 2) must not restart the PC.
  task automatic test_sequential();
    obs_t e;
    obs_t o;
    doReset();
    fillInc();
    for (int k = 0; k < 5; k++) pushExp(10'(k), 3'b001, 1'b1, k[0], 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    while (sbq.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sbq.pop_front(); o = mainObs(); checks++;
      if (o !== e) $display("[TB] FAIL seq_fetch got=%h exp=%h", o, e); else passed++;
      if (e.addr == 10'd2) start = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_branch();
    obs_t e;
    obs_t o;
    doReset();
    fillInc();
    for (int k = 0; k < 6; k++) pushExp(10'(k), 3'b001, 1'b1, k[0], 1'b0, 1'b0, 1'b0);
    pushExp(10'h020, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(10'h021, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    while (sbq.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sbq.pop_front(); o = mainObs(); checks++;
      if (o !== e) $display("[TB] FAIL branch got=%h exp=%h", o, e); else passed++;
      branchTaken  = (e.addr == 10'd5);
      branchTarget = (e.addr == 10'd5) ? 10'h020 : 10'h3AA;
    end
    branchTaken = 1'b0;
  endtask

  // PREP sets prep mode, PSFT and 111 hold it (111 is a no-op), PREP inside prep clears it, then 111 halts.
  task automatic test_prep_halt();
    obs_t e;
    obs_t o;
    doReset();
    fillInc();
    rom[0] = 9'h000;
    rom[1] = 9'h141;
    rom[2] = 9'h1C0;
    rom[3] = 9'h001;
    rom[4] = 9'h1C1;
    pushExp(10'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(10'd1, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(10'd2, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    pushExp(10'd3, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    pushExp(10'd4, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) pushExp(10'd4, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    start = 1'b1;
    while (sbq.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sbq.pop_front(); o = mainObs(); checks++;
      if (o !== e) $display("[TB] FAIL prep_halt got=%h exp=%h", o, e); else passed++;
      branchTaken  = (e.addr == 10'd4);
      branchTarget = 10'h030;
    end
    branchTaken = 1'b0;
`ifdef FETCH_INSTR_COUNT_EN
    checks++;
    if (instrCount !== 32'd5) $display("[TB] FAIL halt_count got=%0d exp=5", instrCount); else passed++;
`endif
  endtask

  task automatic test_restart();
    obs_t e;
    obs_t o;
    fillInc();
    for (int k = 0; k < 3; k++) pushExp(10'(k), 3'b001, 1'b1, k[0], 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    while (sbq.size() > 0) begin
      @(negedge clk);
      start = 1'b0;
      e = sbq.pop_front(); o = mainObs(); checks++;
      if (o !== e) $display("[TB] FAIL restart got=%h exp=%h", o, e); else passed++;
    end
`ifdef FETCH_INSTR_COUNT_EN
    checks++;
    if (instrCount !== 32'd2) $display("[TB] FAIL restart_count got=%0d exp=2", instrCount); else passed++;
`endif
  endtask

  // Branch to 0 must not flag a wrap; the incrementing 15->0 must, sticky until a restart from HALT.
  task automatic test_wrap();
    obs_t e;
    obs_t o;
    int   n;
    doReset();
    fillInc();
    for (int k = 0; k < 4; k++) pushExp(10'(k), 3'b001, 1'b1, k[0], 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 16; k++) pushExp(10'(k), 3'b001, 1'b1, k[0], 1'b0, 1'b0, 1'b0);
    pushExp(10'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(10'd1, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    pushExp(10'd9, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    pushExp(10'd9, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    pushExp(10'd0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    pushExp(10'd1, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    start4 = 1'b1;
    while (sbq.size() > 0) begin
      @(negedge clk);
      start4 = 1'b0;
      branchTaken4 = 1'b0;
      e = sbq.pop_front(); o = wrapObs(); checks++;
      if (o !== e) $display("[TB] FAIL wrap step=%0d got=%h exp=%h", n, o, e); else passed++;
      if (n == 3) begin
        branchTaken4 = 1'b1;
        branchTarget4 = 4'd0;
      end else if (n == 21) begin
        branchTaken4 = 1'b1;
        branchTarget4 = 4'd9;
        rom4[9] = 9'h1C0;
      end else if (n == 23) begin
        start4 = 1'b1;
      end
      n++;
    end
    branchTaken4 = 1'b0;
    start4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_prep_halt();
    test_restart();
    test_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
